// File: rtl/alu_op_sequencer_if.sv
// rtl/alu_op_sequencer_if.sv - issue, register-file, ALU unit and writeback signals of the ALU op sequencer
interface alu_op_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 5
);
  logic                instr_valid;
  logic                instr_ready;
  logic [31:0]         instr;
  logic [REG_AW-1:0]   rf_rd_addr_a;
  logic [REG_AW-1:0]   rf_rd_addr_b;
  logic [DATA_W-1:0]   rf_rd_data_a;
  logic [DATA_W-1:0]   rf_rd_data_b;
  logic [DATA_W-1:0]   op_a;
  logic [DATA_W-1:0]   op_b;
  logic [5:0]          alu_sel;
  logic [DATA_W-1:0]   alu_result;
  logic                muldiv_start;
  logic                muldiv_done;
  logic [2*DATA_W-1:0] mul_result;
  logic [DATA_W-1:0]   div_result;
  logic                wb_en;
  logic [REG_AW-1:0]   wb_addr;
  logic [DATA_W-1:0]   wb_data;
  logic                busy;
  logic                err;
  logic [1:0]          err_code;

  modport master (
    input  instr_valid, instr, rf_rd_data_a, rf_rd_data_b, alu_result,
           muldiv_done, mul_result, div_result,
    output instr_ready, rf_rd_addr_a, rf_rd_addr_b, op_a, op_b, alu_sel,
           muldiv_start, wb_en, wb_addr, wb_data, busy, err, err_code
  );

  modport slave (
    output instr_valid, instr, rf_rd_data_a, rf_rd_data_b, alu_result,
           muldiv_done, mul_result, div_result,
    input  instr_ready, rf_rd_addr_a, rf_rd_addr_b, op_a, op_b, alu_sel,
           muldiv_start, wb_en, wb_addr, wb_data, busy, err, err_code
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - multi-cycle sequencer of one instruction through the 16-bit ALU datapath
// Optional retired/stall counters under ALU_OP_SEQUENCER_PERF_EN.
module alu_op_sequencer #(
  parameter int DATA_W         = 16,
  parameter int REG_AW         = 5,
  parameter int MULDIV_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_op_sequencer_if.master bus
`ifdef ALU_OP_SEQUENCER_PERF_EN
  ,
  output logic [31:0]        retired_cnt,
  output logic [31:0]        stall_cnt
`endif
);
  localparam int         CNT_W  = (MULDIV_TIMEOUT > 2) ? $clog2(MULDIV_TIMEOUT) : 1;
  localparam logic [5:0] OP_MUL = 6'd7;
  localparam logic [5:0] OP_DIV = 6'd8;

  typedef enum logic [2:0] {IDLE, READ, EXEC, WAIT, WB_LO, WB_HI} state_t;

  state_t            state;
  logic [31:0]       instr_q;
  logic [DATA_W-1:0] hi_q;
  logic [CNT_W-1:0]  wait_cnt;
  logic [5:0]        opcode;

  assign opcode = instr_q[31:26];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      instr_q          <= '0;
      hi_q             <= '0;
      wait_cnt         <= '0;
      bus.instr_ready  <= 1'b0;
      bus.rf_rd_addr_a <= '0;
      bus.rf_rd_addr_b <= '0;
      bus.op_a         <= '0;
      bus.op_b         <= '0;
      bus.alu_sel      <= '0;
      bus.muldiv_start <= 1'b0;
      bus.wb_en        <= 1'b0;
      bus.wb_addr      <= '0;
      bus.wb_data      <= '0;
      bus.busy         <= 1'b0;
      bus.err          <= 1'b0;
      bus.err_code     <= '0;
`ifdef ALU_OP_SEQUENCER_PERF_EN
      retired_cnt      <= '0;
      stall_cnt        <= '0;
`endif
    end else begin
      bus.wb_en        <= 1'b0;
      bus.muldiv_start <= 1'b0;
      bus.err          <= 1'b0;
      case (state)
        IDLE: begin
          bus.instr_ready <= 1'b1;
          if (bus.instr_valid && bus.instr_ready) begin
            instr_q          <= bus.instr;
            bus.rf_rd_addr_a <= REG_AW'(bus.instr[4:0]);
            bus.rf_rd_addr_b <= REG_AW'(bus.instr[9:5]);
            bus.instr_ready  <= 1'b0;
            bus.busy         <= 1'b1;
            state            <= READ;
          end
        end
        READ: begin
          bus.op_a    <= bus.rf_rd_data_a;
          bus.op_b    <= bus.rf_rd_data_b;
          bus.alu_sel <= opcode;
          state       <= EXEC;
        end
        EXEC: begin
          // Writeback to Rdst1 is the common case; MUL/DIV and illegal opcodes cancel it below.
          state       <= WB_LO;
          bus.wb_en   <= 1'b1;
          bus.wb_addr <= REG_AW'(instr_q[20:16]);
          case (opcode) inside
            6'd0:                      bus.wb_data <= bus.op_a;
            6'd1:                      bus.wb_data <= DATA_W'(instr_q[15:0]);
            [6'd4:6'd6], [6'd9:6'd16]: bus.wb_data <= bus.alu_result;
            OP_MUL, OP_DIV: begin
              if (opcode == OP_DIV && bus.op_a == '0) begin
                bus.wb_data  <= '1;
                bus.err      <= 1'b1;
                bus.err_code <= 2'd1;
              end else begin
                bus.wb_en        <= 1'b0;
                bus.muldiv_start <= 1'b1;
                wait_cnt         <= '0;
                state            <= WAIT;
              end
            end
            default: begin
              bus.wb_en       <= 1'b0;
              bus.err         <= 1'b1;
              bus.err_code    <= 2'd0;
              bus.busy        <= 1'b0;
              bus.instr_ready <= 1'b1;
              state           <= IDLE;
            end
          endcase
        end
        WAIT: begin
`ifdef ALU_OP_SEQUENCER_PERF_EN
          stall_cnt <= stall_cnt + 32'd1;
`endif
          // Done wins over the timeout when both land on the last allowed cycle.
          if (bus.muldiv_done) begin
            bus.wb_en   <= 1'b1;
            bus.wb_addr <= REG_AW'(instr_q[20:16]);
            state       <= WB_LO;
            if (opcode == OP_MUL) begin
              bus.wb_data <= bus.mul_result[DATA_W-1:0];
              hi_q        <= bus.mul_result[2*DATA_W-1:DATA_W];
            end else begin
              bus.wb_data <= bus.div_result;
            end
          end else if (wait_cnt == CNT_W'(MULDIV_TIMEOUT - 1)) begin
            bus.err         <= 1'b1;
            bus.err_code    <= 2'd2;
            bus.busy        <= 1'b0;
            bus.instr_ready <= 1'b1;
            state           <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        WB_LO: begin
          if (opcode == OP_MUL) begin
            bus.wb_en   <= 1'b1;
            bus.wb_addr <= REG_AW'(instr_q[25:21]);
            bus.wb_data <= hi_q;
            state       <= WB_HI;
          end else begin
            bus.busy        <= 1'b0;
            bus.instr_ready <= 1'b1;
            state           <= IDLE;
`ifdef ALU_OP_SEQUENCER_PERF_EN
            retired_cnt     <= retired_cnt + 32'd1;
`endif
          end
        end
        WB_HI: begin
          bus.busy        <= 1'b0;
          bus.instr_ready <= 1'b1;
          state           <= IDLE;
`ifdef ALU_OP_SEQUENCER_PERF_EN
          retired_cnt     <= retired_cnt + 32'd1;
`endif
        end
        default: begin
          bus.busy        <= 1'b0;
          bus.instr_ready <= 1'b1;
          state           <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed and randomised self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;
  localparam int TMO = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_op_sequencer_if #(.DATA_W(16), .REG_AW(5)) bus ();

`ifdef ALU_OP_SEQUENCER_PERF_EN
  logic [31:0] retired_cnt;
  logic [31:0] stall_cnt;
`endif

  alu_op_sequencer #(.DATA_W(16), .REG_AW(5), .MULDIV_TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus)
`ifdef ALU_OP_SEQUENCER_PERF_EN
    ,
    .retired_cnt (retired_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  logic [15:0] regs [32];
  logic [15:0] cur_alu;
  logic [15:0] cur_div;
  logic [31:0] cur_mul;

  assign bus.rf_rd_data_a = regs[bus.rf_rd_addr_a];
  assign bus.rf_rd_data_b = regs[bus.rf_rd_addr_b];
  assign bus.alu_result   = cur_alu;
  assign bus.mul_result   = cur_mul;
  assign bus.div_result   = cur_div;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {4'b0, bus.instr_ready, bus.rf_rd_addr_a, bus.rf_rd_addr_b, bus.alu_sel,
        bus.muldiv_start, bus.wb_en, bus.wb_addr, bus.busy, bus.err, bus.err_code}, 32'd0);
    chk({tag, "_ops"}, {bus.op_a, bus.op_b}, 32'd0);
    chk({tag, "_wbd"}, {16'd0, bus.wb_data}, 32'd0);
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (bus.instr_ready !== 1'b1 && guard < 200) begin
      step();
      guard++;
    end
    chk("ready_wait", {31'd0, bus.instr_ready}, 32'd1);
  endtask

  // Reference: the expected per-cycle timeline, relative to the accept cycle, derived from the opcode rules.
  // k = WAIT cycle (1-based) in which muldiv_done is raised; k = 0 means never.
  task automatic run_instr(input logic [5:0] op, input logic [4:0] rd2, input logic [4:0] rd1,
                           input logic [4:0] rs2, input logic [4:0] rs1, input logic [5:0] imm_hi,
                           input int k, input logic [15:0] alu_val);
    logic [31:0] word;
    logic [15:0] a, b, lo_data, hi_data;
    logic [31:0] prod;
    logic [1:0]  ecode;
    int ready_n, wb_lo_n, wb_hi_n, err_n, start_n;
    bit is_md;
    word    = {op, rd2, rd1, imm_hi, rs2, rs1};
    a       = regs[rs1];
    b       = regs[rs2];
    prod    = {16'd0, a} * {16'd0, b};
    wb_lo_n = -1; wb_hi_n = -1; err_n = -1; start_n = -1;
    ecode   = 2'd0; lo_data = 16'd0; hi_data = prod[31:16]; is_md = 1'b0; ready_n = 4;
    if (op == 6'd0) begin
      wb_lo_n = 3; lo_data = a;
    end else if (op == 6'd1) begin
      wb_lo_n = 3; lo_data = word[15:0];
    end else if ((op >= 6'd4 && op <= 6'd6) || (op >= 6'd9 && op <= 6'd16)) begin
      wb_lo_n = 3; lo_data = alu_val;
    end else if (op == 6'd8 && a == 16'd0) begin
      wb_lo_n = 3; lo_data = 16'hFFFF; err_n = 3; ecode = 2'd1;
    end else if (op == 6'd7 || op == 6'd8) begin
      is_md = 1'b1; start_n = 3;
      if (k == 0) begin
        err_n = 3 + TMO; ecode = 2'd2; ready_n = err_n;
      end else begin
        wb_lo_n = 3 + k;
        lo_data = (op == 6'd7) ? prod[15:0] : b / a;
        if (op == 6'd7) begin
          wb_hi_n = 4 + k; ready_n = 5 + k;
        end else begin
          ready_n = 4 + k;
        end
      end
    end else begin
      err_n = 3; ecode = 2'd0; ready_n = 3;
    end
    cur_alu = alu_val;
    cur_mul = prod;
    cur_div = (a == 16'd0) ? 16'hDEAD : b / a;
    wait_ready();
    bus.instr       = word;
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    bus.instr       = $urandom;
    for (int n = 1; n <= ready_n; n++) begin
      if (is_md) bus.muldiv_done = (k != 0 && n == 2 + k) || (n <= 2 && $urandom_range(0, 1) == 1);
      else       bus.muldiv_done = ($urandom_range(0, 1) == 1);
      chk("wb_en", {31'd0, bus.wb_en}, {31'd0, (n == wb_lo_n || n == wb_hi_n)});
      if (n == wb_lo_n) begin
        chk("wb_lo_addr", {27'd0, bus.wb_addr}, {27'd0, rd1});
        chk("wb_lo_data", {16'd0, bus.wb_data}, {16'd0, lo_data});
      end
      if (n == wb_hi_n) begin
        chk("wb_hi_addr", {27'd0, bus.wb_addr}, {27'd0, rd2});
        chk("wb_hi_data", {16'd0, bus.wb_data}, {16'd0, hi_data});
      end
      chk("err", {31'd0, bus.err}, {31'd0, (n == err_n)});
      if (n == err_n) chk("err_code", {30'd0, bus.err_code}, {30'd0, ecode});
      chk("muldiv_start", {31'd0, bus.muldiv_start}, {31'd0, (n == start_n)});
      chk("busy", {31'd0, bus.busy}, {31'd0, (n != ready_n)});
      chk("instr_ready", {31'd0, bus.instr_ready}, {31'd0, (n == ready_n)});
      if (n == 1) chk("rd_addr", {22'd0, bus.rf_rd_addr_b, bus.rf_rd_addr_a}, {22'd0, rs2, rs1});
      if (n == 2) begin
        chk("operands", {bus.op_a, bus.op_b}, {a, b});
        chk("alu_sel", {26'd0, bus.alu_sel}, {26'd0, op});
      end
      if (n < ready_n) step();
    end
    bus.muldiv_done = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] op;
    int sel, k, r;
    logic [4:0] rs1;

    for (int i = 0; i < 32; i++) regs[i] = 16'($urandom);
    regs[0] = 16'd0;
    cur_alu = '0; cur_mul = '0; cur_div = '0;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.muldiv_done = 1'b0;
    rst_n = 1'b0;
    repeat (3) step();
    chk_all_zero("reset");
`ifdef ALU_OP_SEQUENCER_PERF_EN
    chk("perf_reset", retired_cnt | stall_cnt, 32'd0);
`endif
    rst_n = 1'b1;

    regs[1] = 16'd5; regs[2] = 16'd7;
    run_instr(6'd4, 5'd0, 5'd3, 5'd2, 5'd1, 6'd0, 0, 16'd12);
    regs[4] = 16'h1234; regs[5] = 16'h0100;
    run_instr(6'd7, 5'd9, 5'd8, 5'd5, 5'd4, 6'd0, 3, 16'h0);
    regs[6] = 16'd9;
    run_instr(6'd8, 5'd0, 5'd10, 5'd6, 5'd0, 6'd0, 1, 16'h0);
    run_instr(6'd7, 5'd9, 5'd8, 5'd5, 5'd4, 6'd0, 0, 16'h0);
    run_instr(6'd2, 5'd1, 5'd2, 5'd3, 5'd4, 6'd0, 0, 16'h0);
    run_instr(6'd40, 5'd1, 5'd2, 5'd3, 5'd4, 6'd0, 0, 16'h0);
    run_instr(6'd7, 5'd11, 5'd12, 5'd5, 5'd4, 6'd0, TMO, 16'h0);
    run_instr(6'd8, 5'd0, 5'd13, 5'd4, 5'd6, 6'd0, 1, 16'h0);
    run_instr(6'd1, 5'd0, 5'd14, 5'd31, 5'd31, 6'h2A, 0, 16'h0);
    run_instr(6'd0, 5'd0, 5'd15, 5'd0, 5'd4, 6'd0, 0, 16'h0);

    // Reset while the multiplier is outstanding, then a late done.
    wait_ready();
    bus.instr       = {6'd7, 5'd9, 5'd8, 6'd0, 5'd5, 5'd4};
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    repeat (4) step();
    chk("mid_wait_busy", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    step();
    chk_all_zero("mid_reset");
    rst_n = 1'b1;
    bus.muldiv_done = 1'b1;
    repeat (3) begin
      step();
      chk("late_done", {29'd0, bus.wb_en, bus.muldiv_start, bus.err}, 32'd0);
    end
    bus.muldiv_done = 1'b0;
    run_instr(6'd4, 5'd0, 5'd3, 5'd2, 5'd1, 6'd0, 0, 16'd12);

    for (int i = 1; i < 32; i++) regs[i] = 16'($urandom);
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      k   = $urandom_range(1, 8);
      rs1 = 5'($urandom);
      case (sel)
        0, 1: begin
          r  = $urandom_range(0, 10);
          op = (r < 3) ? 6'(4 + r) : 6'(6 + r);
        end
        2:       op = 6'd0;
        3:       op = 6'd1;
        4, 5:    op = 6'd7;
        6, 7: begin
          op = 6'd8;
          if ($urandom_range(0, 3) == 0) rs1 = 5'd0;
        end
        8: begin
          r  = $urandom_range(0, 48);
          op = (r < 2) ? 6'(2 + r) : 6'(15 + r);
        end
        default: begin
          op = ($urandom_range(0, 1) == 1) ? 6'd7 : 6'd8;
          k  = ($urandom_range(0, 1) == 1) ? 0 : TMO;
        end
      endcase
      run_instr(op, 5'($urandom), 5'($urandom), 5'($urandom), rs1, 6'($urandom), k, 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
